mem_slave_responder: RTL and testbench

- Synthesisable single-port memory target that sits on the slave end of the team's `mem_interface` bus.
- Accepts read and write requests from any master, e.g. the CODMA engine, and returns grant, read data and error responses.
- Serves as the standard memory endpoint for the DMA environment.
- Also documents the responder side of the bus protocol at cycle level.

---
 rtl/mem_slave_responder.sv | 154 +++++++++++++++
 tb/tb_mem_slave_responder.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_slave_responder.sv
// mem_slave_responder
// Single-port 64-bit memory target on the slave side of the mem_interface bus.
// A request (read/write/addr/size) is held by the master until grant pulses.
// The target then returns N = 1<<size read beats, accepts N write beats, or
// pulses error for one cycle when the request is illegal.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   read, write  address-phase request (held until grant)
//   addr, size   byte address and burst size (0/1/2 -> 1/2/4 dwords)
//   grant        one-cycle pulse ending the address phase
//   read_data    read beat data, meaningful while read_valid=1
//   read_valid   read beat strobe
//   write_data   write beat data
//   write_valid  write beat strobe, honoured only in the data phase
//   error        one-cycle failure response
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for read|write
// WAIT   | GRANT_WAIT idle cycles before granting
// GRANT  | grant high; captured request is decoded
// RD     | streaming N read beats on consecutive cycles
// WR     | accepting N write beats, gaps allowed
// ERR    | error high for one cycle, nothing moved
module mem_slave_responder #(
    parameter int unsigned DEPTH      = 1024,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned GRANT_WAIT = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [3:0]  size,
    output logic        grant,
    output logic [63:0] read_data,
    output logic        read_valid,
    input  logic [63:0] write_data,
    input  logic        write_valid,
    output logic        error
);

    localparam int unsigned IDXW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] MEM_BYTES = 33'(DEPTH) << 3;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_GRANT, S_RD, S_WR, S_ERR
    } state_t;

    state_t          state, next_state;
    logic [3:0]      wait_cnt, wait_d;
    logic [2:0]      beat, beat_d;
    logic [31:0]     cap_addr;
    logic [3:0]      cap_size;
    logic            cap_rd, cap_wr;
    logic [63:0]     mem [DEPTH];

    logic [32:0]     offset, burst_end;
    logic            illegal;
    logic [2:0]      n_beats;
    logic [IDXW-1:0] base_idx, beat_idx, rd_idx;
    logic            grant_d, read_valid_d, error_d, load_data, mem_we, capture;

    // Request decode works on the captured request; 33-bit arithmetic keeps
    // the end-of-burst compare free of wrap-around.
    always_comb begin
        offset    = {1'b0, cap_addr} - {1'b0, BASE_ADDR};
        burst_end = offset + (33'd8 << cap_size);
        illegal   = (cap_rd & cap_wr) | (cap_size > 4'd2) | (cap_addr[2:0] != 3'b000) |
                    (cap_addr < BASE_ADDR) | (burst_end > MEM_BYTES);
        n_beats   = 3'd1 << cap_size[1:0];
        base_idx  = offset[IDXW+2:3];
        beat_idx  = base_idx + IDXW'(beat);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (read | write) next_state = (GRANT_WAIT > 0) ? S_WAIT : S_GRANT;
            S_WAIT:  if (wait_cnt == 4'd0) next_state = S_GRANT;
            S_GRANT: next_state = illegal ? S_ERR : (cap_rd ? S_RD : S_WR);
            S_RD:    if (beat == n_beats) next_state = S_IDLE;
            S_WR:    if (write_valid && (beat + 3'd1 == n_beats)) next_state = S_IDLE;
            S_ERR:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath controls.
    always_comb begin
        grant_d      = (next_state == S_GRANT);
        read_valid_d = (next_state == S_RD);
        error_d      = (next_state == S_ERR);
        load_data    = (next_state == S_RD);
        rd_idx       = (state == S_GRANT) ? base_idx : beat_idx;
        mem_we       = (state == S_WR) && write_valid;
        capture      = ((state == S_IDLE) || (state == S_WAIT)) && (next_state == S_GRANT);
        beat_d       = 3'd0;
        wait_d       = 4'd0;
        case (state)
            S_IDLE:  if (next_state == S_WAIT) wait_d = 4'(GRANT_WAIT) - 4'd1;
            S_WAIT:  if (wait_cnt != 4'd0) wait_d = wait_cnt - 4'd1;
            S_GRANT: beat_d = (next_state == S_RD) ? 3'd1 : 3'd0;
            S_RD:    beat_d = (next_state == S_RD) ? beat + 3'd1 : 3'd0;
            S_WR:    beat_d = write_valid ? beat + 3'd1 : beat;
            default: beat_d = 3'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant      <= 1'b0;
            read_valid <= 1'b0;
            error      <= 1'b0;
            read_data  <= 64'd0;
            beat       <= 3'd0;
            wait_cnt   <= 4'd0;
            cap_addr   <= 32'd0;
            cap_size   <= 4'd0;
            cap_rd     <= 1'b0;
            cap_wr     <= 1'b0;
        end else begin
            grant      <= grant_d;
            read_valid <= read_valid_d;
            error      <= error_d;
            beat       <= beat_d;
            wait_cnt   <= wait_d;
            if (load_data) read_data <= mem[rd_idx];
            // The master holds the request stable until grant, so latching
            // it on the way into GRANT lets it drop during the grant cycle.
            if (capture) begin
                cap_addr <= addr;
                cap_size <= size;
                cap_rd   <= read;
                cap_wr   <= write;
            end
        end
    end

    // Storage has no reset; state returns to IDLE under reset so no write
    // can land once reset_n falls.
    always_ff @(posedge clk) begin
        if (mem_we) mem[beat_idx] <= write_data;
    end

endmodule

// File: tb/tb_mem_slave_responder.sv
module tb_mem_slave_responder;

    localparam int DEPTH  = 64;
    localparam int BASE   = 0;
    localparam int DEPTH3 = 16;
    localparam int BASE3  = 32'h1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        read, write, grant, read_valid, write_valid, error;
    logic [31:0] addr;
    logic [3:0]  size;
    logic [63:0] read_data, write_data;

    logic        b_read, b_write, b_grant, b_read_valid, b_write_valid, b_error;
    logic [31:0] b_addr;
    logic [3:0]  b_size;
    logic [63:0] b_read_data, b_write_data;

    always #5 clk = ~clk;

    mem_slave_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .GRANT_WAIT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .read(read), .write(write), .addr(addr), .size(size),
        .grant(grant), .read_data(read_data), .read_valid(read_valid),
        .write_data(write_data), .write_valid(write_valid), .error(error));

    mem_slave_responder #(.DEPTH(DEPTH3), .BASE_ADDR(BASE3), .GRANT_WAIT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .read(b_read), .write(b_write), .addr(b_addr), .size(b_size),
        .grant(b_grant), .read_data(b_read_data), .read_valid(b_read_valid),
        .write_data(b_write_data), .write_valid(b_write_valid), .error(b_error));

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_err;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [63:0] ref_mem [DEPTH];
    logic [63:0] wbuf [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Reference legality: plain integer arithmetic on the request.
    function automatic bit model_legal(input bit rd, input bit wr, input logic [31:0] a,
                                       input logic [3:0] s);
        longint la, off;
        la = longint'(a);
        if (rd && wr) return 0;
        if (s > 2) return 0;
        if (la % 8 != 0) return 0;
        if (la < BASE) return 0;
        off = la - BASE;
        if (off + 8 * (longint'(1) << s) > 8 * longint'(DEPTH)) return 0;
        return 1;
    endfunction

    // Monitor: pops one expectation for every beat or error the DUT presents.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (read_valid === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rd_beat: got unexpected beat %h, required none", read_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_err || read_data !== mon_e.data) begin
                        bad++;
                        $display("FAIL rd_beat: got data %h, required %s %h", read_data,
                                 mon_e.is_err ? "error" : "data", mon_e.data);
                    end
                end
            end
            if (error === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL err_resp: got unexpected error, required none");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e.is_err) begin
                        bad++;
                        $display("FAIL err_resp: got error, required read beat %h", mon_e.data);
                    end
                end
            end
        end
    end

    task automatic request(input bit rd, input bit wr, input logic [31:0] a,
                           input logic [3:0] s, output int lat);
        bit seen;
        read  = rd;
        write = wr;
        addr  = a;
        size  = s;
        seen  = 0;
        lat   = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            lat = i;
            if (grant === 1'b1) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL grant_timeout: got no grant in %0d cycles, required grant", lat);
        end
        read  = 1'b0;
        write = 1'b0;
    endtask

    // Called at the grant negedge: queue expectations and drive write beats.
    task automatic serve(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] s,
                         input int gap_at, input int gap_len, input bit junk);
        exp_t e;
        int   n, idx;
        write_valid = junk;
        write_data  = {$urandom, $urandom};
        if (!model_legal(rd, wr, a, s)) begin
            e.is_err = 1;
            e.data   = '0;
            exp_q.push_back(e);
            if (wr) begin
                @(negedge clk);
                write_valid = 1'b1;
                write_data  = {$urandom, $urandom};
            end
            @(negedge clk);
            write_valid = 1'b0;
        end else begin
            n   = 1 << s;
            idx = (int'(a) - BASE) / 8;
            if (rd) begin
                for (int k = 0; k < n; k++) begin
                    e.is_err = 0;
                    e.data   = ref_mem[idx + k];
                    exp_q.push_back(e);
                end
                @(negedge clk);
                write_valid = 1'b0;
            end else begin
                for (int k = 0; k < n; k++) begin
                    if (k == gap_at) begin
                        repeat (gap_len) begin
                            @(negedge clk);
                            write_valid = 1'b0;
                        end
                    end
                    @(negedge clk);
                    write_valid      = 1'b1;
                    write_data       = wbuf[k];
                    ref_mem[idx + k] = wbuf[k];
                end
                @(negedge clk);
                write_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending responses, required 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] s,
                       input int gap_at, input int gap_len, input bit junk, output int lat);
        request(rd, wr, a, s, lat);
        serve(rd, wr, a, s, gap_at, gap_len, junk);
        drain();
    endtask

    task automatic b_request(input bit rd, input bit wr, input logic [31:0] a, output int lat);
        b_read  = rd;
        b_write = wr;
        b_addr  = a;
        b_size  = 4'd0;
        lat     = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            lat = i;
            if (b_grant === 1'b1) break;
        end
        b_read  = 1'b0;
        b_write = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         lat, lat2, r, n, gap_at, gap_len;
        bit         rd, wr, junk;
        logic [3:0] s;
        logic [31:0] a;
        exp_t       e;

        reset_n = 1'b0;
        read = 0; write = 0; addr = '0; size = '0; write_data = '0; write_valid = 0;
        b_read = 0; b_write = 0; b_addr = '0; b_size = '0; b_write_data = '0; b_write_valid = 0;
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_read_valid", read_valid, 0);
        chk("rst_error", error, 0);
        chk("rst_read_data", read_data, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_grant", grant, 0);

        // Fill memory so every later read has a known reference.
        for (int i = 0; i < DEPTH / 4; i++) begin
            for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
            txn(0, 1, 32'(BASE + i * 32), 4'd2, 4, 0, 0, lat);
        end

        // Single write then read.
        wbuf[0] = 64'hDEAD_BEEF_0123_4567;
        txn(0, 1, 32'h40, 4'd0, 4, 0, 0, lat);
        chk("wr_grant_lat", lat, 1);
        txn(1, 0, 32'h40, 4'd0, 4, 0, 0, lat);
        chk("rd_grant_lat", lat, 1);

        // Four-beat write with a 2-cycle gap after beat 2, junk strobe during grant.
        wbuf[0] = 64'd1; wbuf[1] = 64'd2; wbuf[2] = 64'd3; wbuf[3] = 64'd4;
        txn(0, 1, 32'h100, 4'd2, 2, 2, 1, lat);
        txn(1, 0, 32'h100, 4'd2, 4, 0, 0, lat);

        // Illegal requests, then confirm memory untouched.
        txn(1, 0, 32'h0,   4'd3, 4, 0, 0, lat);
        txn(1, 0, 32'h44,  4'd0, 4, 0, 0, lat);
        txn(1, 1, 32'h40,  4'd0, 4, 0, 1, lat);
        txn(1, 0, 32'(8 * DEPTH - 16), 4'd2, 4, 0, 0, lat);
        txn(0, 1, 32'h40,  4'd3, 4, 0, 1, lat);
        txn(1, 0, 32'h40,  4'd0, 4, 0, 0, lat);
        txn(1, 0, 32'h100, 4'd2, 4, 0, 0, lat);

        // GRANT_WAIT=3 instance: read timing, then a below-base request.
        b_request(1, 0, 32'(BASE3), lat);
        chk("gw3_grant_lat", lat, 4);
        @(negedge clk);
        chk("gw3_first_rv", b_read_valid, 1);
        chk("gw3_no_err", b_error, 0);
        @(negedge clk);
        chk("gw3_rv_done", b_read_valid, 0);
        repeat (2) @(negedge clk);
        b_request(0, 1, 32'(BASE3 - 8), lat);
        chk("gw3_err_grant_lat", lat, 4);
        @(negedge clk);
        chk("gw3_below_base_err", b_error, 1);
        chk("gw3_below_base_rv", b_read_valid, 0);
        @(negedge clk);
        chk("gw3_err_pulse", b_error, 0);

        // Request held during a burst; the held one is the last-word read.
        request(1, 0, 32'h100, 4'd2, lat);
        serve(1, 0, 32'h100, 4'd2, 4, 0, 0);
        request(1, 0, 32'(BASE + 8 * (DEPTH - 1)), 4'd0, lat2);
        #1;
        chk("held_after_burst", exp_q.size(), 0);
        chk("held_grant_lat", lat2, 5);
        serve(1, 0, 32'(BASE + 8 * (DEPTH - 1)), 4'd0, 4, 0, 0);
        drain();

        // Reset during beat 2 of a 4-beat read.
        request(1, 0, 32'h100, 4'd2, lat);
        for (int k = 0; k < 2; k++) begin
            e.is_err = 0;
            e.data   = ref_mem[32 + k];
            exp_q.push_back(e);
        end
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
            #1;
        end
        chk("beats_before_reset", exp_q.size(), 0);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_grant", grant, 0);
        chk("mid_rst_read_valid", read_valid, 0);
        chk("mid_rst_error", error, 0);
        chk("mid_rst_read_data", read_data, 0);
        repeat (3) @(negedge clk);
        chk("rst_hold_read_valid", read_valid, 0);
        reset_n = 1'b1;
        repeat (6) @(negedge clk);
        txn(1, 0, 32'h100, 4'd2, 4, 0, 0, lat);
        chk("post_rst_grant_lat", lat, 1);

        // Randomized traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            r  = $urandom_range(0, 9);
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            s  = 4'($urandom_range(0, 2));
            n  = 1 << s;
            a  = 32'(BASE + $urandom_range(0, DEPTH - n) * 8);
            if (r == 0) begin
                case ($urandom_range(0, 3))
                    0: s = 4'($urandom_range(3, 15));
                    1: a = a | 32'($urandom_range(1, 7));
                    2: begin rd = 1; wr = 1; end
                    default: a = 32'(BASE + $urandom_range(DEPTH - n + 1, DEPTH + 3) * 8);
                endcase
            end
            for (int k = 0; k < 4; k++) wbuf[k] = {$urandom, $urandom};
            gap_at  = $urandom_range(0, 3);
            gap_len = $urandom_range(0, 2);
            junk    = 1'($urandom_range(0, 1));
            txn(rd, wr, a, s, gap_at, gap_len, junk, lat);
        end

        drain();
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
